pll_reset_sequencer: RTL and testbench

//  Consumes the PLL lock flag and the PLL output clock. Produces staged, glitch-free, active-low resets for the design logic.
//  - Filters lock bounce at PLL start-up.
//  - Holds all resets after lock is stable.
//  - Releases the reset stages in order: memory/video first, CPU last.
//  - Re-asserts every reset if lock is lost during operation.

---
 rtl/pll_rst_if.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 143 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pll_rst_if.sv
// Lock-flag input and staged-reset outputs of the PLL reset sequencer.
// master = sequencer side, slave = PLL/consumer side.
interface pll_rst_if #(
    parameter int NUM_STAGES = 3
);
    logic                  pll_locked;
    logic [NUM_STAGES-1:0] rst_out_n;
    logic                  ready;
    logic [1:0]            state;
    logic [7:0]            loss_count;

    modport master (
        input  pll_locked,
        output rst_out_n,
        output ready,
        output state,
        output loss_count
    );

    modport slave (
        output pll_locked,
        input  rst_out_n,
        input  ready,
        input  state,
        input  loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Staged, glitch-free active-low reset generator driven by the PLL lock flag.
// Optional lock-loss event counter enabled by defining PLLRST_LOSS_COUNT_EN.
module pll_reset_sequencer #(
    parameter int LOCK_STABLE = 1024,
    parameter int HOLD_CYCLES = 256,
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_GAP   = 16,
    parameter int GLITCH_MAX  = 4,
    parameter int CNT_W       = 16
) (
    input logic       clock,
    input logic       reset_n,
    pll_rst_if.master bus
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] GLITCH_LIM = CNT_W'(GLITCH_MAX);
    localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);

    logic                  lock_meta;
    logic                  lock_s;
    state_t                state_q;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      gcnt;
    logic [NUM_STAGES-1:0] rst_q;
    logic                  ready_q;
    logic                  lose_lock;

    // Two-flop synchroniser; pll_locked is asynchronous to clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so lock_s takes the old lock_meta, giving two real flop stages.
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives lose_lock and no latch is inferred.
        lose_lock = 1'b0;
        case (state_q)
            HOLD, RELEASE: lose_lock = !lock_s;
            RUN:           lose_lock = !lock_s && (gcnt == GLITCH_LIM);
            default:       lose_lock = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            cnt     <= '0;
            gcnt    <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
        end else if (lose_lock) begin
            // Any accepted loss pulls every stage back into reset on this edge.
            state_q <= WAIT_LOCK;
            cnt     <= '0;
            gcnt    <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state_q <= HOLD;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_q <= RELEASE;
                        cnt     <= '0;
                        rst_q   <= FIRST_STAGE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (&rst_q) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                            gcnt    <= '0;
                        end else begin
                            // Stages release in order, so shifting in a one frees the next bit.
                            rst_q <= (rst_q << 1) | FIRST_STAGE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (lock_s) begin
                        gcnt <= '0;
                    end else begin
                        gcnt <= gcnt + CNT_W'(1);
                    end
                end
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    assign bus.rst_out_n = rst_q;
    assign bus.ready     = ready_q;
    assign bus.state     = state_q;

`ifdef PLLRST_LOSS_COUNT_EN
    logic [7:0] loss_q;

    // Counts only RUN->WAIT_LOCK transitions and saturates at 255.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else if (lose_lock && (state_q == RUN) && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign bus.loss_count = loss_q;
`else
    assign bus.loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed table, corner sequences,
// and randomised lock patterns against an elapsed-time reference model.
module tb_pll_reset_sequencer;

    localparam int LS     = 8;
    localparam int HC     = 4;
    localparam int NS     = 3;
    localparam int GAP    = 2;
    localparam int GM     = 2;
    localparam int RUN_AT = HC + NS * GAP;

`ifdef PLLRST_LOSS_COUNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    pll_rst_if #(.NUM_STAGES(NS)) bus ();

    pll_reset_sequencer #(
        .LOCK_STABLE(LS),
        .HOLD_CYCLES(HC),
        .NUM_STAGES (NS),
        .STAGE_GAP  (GAP),
        .GLITCH_MAX (GM),
        .CNT_W      (16)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       rdy;
        logic [1:0] st;
    } vec_t;

    vec_t tbl [11];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: lock history, run lengths and time elapsed since stable lock.
    bit hist[$];
    bit active;
    int lock_run, low_run, elapsed, m_loss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist     = {1'b0, 1'b0};
        active   = 1'b0;
        lock_run = 0;
        low_run  = 0;
        elapsed  = 0;
        m_loss   = 0;
    endtask

    task automatic model_edge(input bit lk);
        bit ls;
        hist.push_back(lk);
        ls = hist.pop_front();
        if (!active) begin
            lock_run = ls ? lock_run + 1 : 0;
            if (lock_run == LS) begin
                active   = 1'b1;
                elapsed  = 0;
                lock_run = 0;
                low_run  = 0;
            end
        end else begin
            elapsed++;
            if (elapsed <= RUN_AT) begin
                if (!ls) active = 1'b0;
            end else begin
                low_run = ls ? 0 : low_run + 1;
                if (low_run > GM) begin
                    active = 1'b0;
                    if (LOSS_EN != 0 && m_loss < 255) m_loss++;
                end
            end
        end
    endtask

    function automatic logic [NS-1:0] exp_rst();
        logic [NS-1:0] r;
        for (int k = 0; k < NS; k++) r[k] = active && (elapsed >= HC + k * GAP);
        return r;
    endfunction

    function automatic logic [1:0] exp_state();
        if (!active)          return 2'd0;
        if (elapsed < HC)     return 2'd1;
        if (elapsed < RUN_AT) return 2'd2;
        return 2'd3;
    endfunction

    // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic step(input bit lk);
        bus.pll_locked = lk;
        @(posedge clock);
        model_edge(lk);
        @(negedge clock);
        check("rst_out_n",  bus.rst_out_n,  exp_rst());
        check("ready",      bus.ready,      active && elapsed >= RUN_AT);
        check("state",      bus.state,      exp_state());
        check("loss_count", bus.loss_count, m_loss);
    endtask

    // Lock held high; cycle i is the i-th rising edge after lock was driven high.
    task automatic run_table(input int first);
        for (int i = first; i <= 21; i++) begin
            step(1'b1);
            foreach (tbl[j]) begin
                if (tbl[j].cyc == i) begin
                    check("tbl_rst",   bus.rst_out_n, tbl[j].rst);
                    check("tbl_ready", bus.ready,     tbl[j].rdy);
                    check("tbl_state", bus.state,     tbl[j].st);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{ 9, 3'b000, 1'b0, 2'd0},
            '{10, 3'b000, 1'b0, 2'd1},
            '{13, 3'b000, 1'b0, 2'd1},
            '{14, 3'b001, 1'b0, 2'd2},
            '{15, 3'b001, 1'b0, 2'd2},
            '{16, 3'b011, 1'b0, 2'd2},
            '{17, 3'b011, 1'b0, 2'd2},
            '{18, 3'b111, 1'b0, 2'd2},
            '{19, 3'b111, 1'b0, 2'd2},
            '{20, 3'b111, 1'b1, 2'd3},
            '{21, 3'b111, 1'b1, 2'd3}
        };

        bus.pll_locked = 1'b0;
        reset_n        = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_rst",   bus.rst_out_n,  3'b000);
        check("reset_ready", bus.ready,      1'b0);
        check("reset_state", bus.state,      2'd0);
        check("reset_loss",  bus.loss_count, 8'd0);
        reset_n = 1'b1;

        // Clean start-up.
        run_table(1);

        // RUN glitch of 2 cycles is absorbed; 3 cycles re-resets.
        repeat (3) step(1'b1);
        repeat (2) step(1'b0);
        repeat (6) step(1'b1);
        check("glitch2_ready", bus.ready,      1'b1);
        check("glitch2_loss",  bus.loss_count, 8'd0);
        for (int s = 1; s <= 6; s++) begin
            step(1'b0);
            check("glitch3_ready", bus.ready, (s < 5) ? 1'b1 : 1'b0);
        end
        check("glitch3_rst",  bus.rst_out_n,  3'b000);
        check("glitch3_loss", bus.loss_count, LOSS_EN);

        // Start-up bounce restarts the stable-lock count.
        repeat (5) step(1'b1);
        step(1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1);
            check("bounce_rst0", bus.rst_out_n[0], (i >= 14) ? 1'b1 : 1'b0);
        end

        // Loss in RELEASE: low first sampled one cycle after stage 1 rises.
        step(1'b0);
        check("rel_loss_17", bus.rst_out_n, 3'b011);
        step(1'b1);
        check("rel_loss_18", bus.rst_out_n, 3'b111);
        step(1'b1);
        check("rel_loss_rst",   bus.rst_out_n, 3'b000);
        check("rel_loss_state", bus.state,     2'd0);
        run_table(3);

        // Async reset mid-RELEASE.
        repeat (6) step(1'b0);
        repeat (16) step(1'b1);
        check("pre_async_rst", bus.rst_out_n, 3'b011);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst",   bus.rst_out_n,  3'b000);
        check("async_ready", bus.ready,      1'b0);
        check("async_state", bus.state,      2'd0);
        check("async_loss",  bus.loss_count, 8'd0);
        model_reset();
        #1 reset_n = 1'b1;
        run_table(1);

        // Randomised lock patterns: long highs and short lows of varying length.
        for (int seg = 0; seg < 150; seg++) begin
            bit v;
            int len;
            v   = ($urandom_range(0, 3) != 0);
            len = v ? $urandom_range(1, 30) : $urandom_range(1, 5);
            repeat (len) step(v);
        end

        // Many RUN losses to exercise saturation.
        for (int n = 0; n < 300; n++) begin
            repeat (22) step(1'b1);
            repeat (5) step(1'b0);
        end
        check("sat_loss", bus.loss_count, (LOSS_EN != 0) ? 8'd255 : 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
